// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg - shared LCD command codes, state/stream encodings and byte helpers
// Rev 1.0
// ============================================================================
package lcd_pkg;

    localparam logic [7:0] LCD_CMD_PREFIX = 8'hFE;
    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_LINE0      = 8'h80;
    localparam logic [7:0] LCD_LINE1      = 8'hC0;
    localparam logic [7:0] LCD_SPACE      = 8'h20;
    localparam int         LCD_NUM_CHARS  = 32;

    localparam logic [1:0] ST_INIT_WAIT = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SEND      = 2'd2;
    localparam logic [1:0] ST_DELAY     = 2'd3;

    localparam logic [1:0] SEL_INIT     = 2'd0;
    localparam logic [1:0] SEL_CLEAR    = 2'd1;
    localparam logic [1:0] SEL_REFRESH  = 2'd2;

    function automatic logic [5:0] stream_last(input logic [1:0] sel);
        return (sel == SEL_REFRESH) ? 6'd35 : 6'd1;
    endfunction

    // Refresh layout: FE 80 c0..c15 FE C0 c16..c31
    function automatic logic [4:0] refresh_addr(input logic [5:0] idx);
        logic [5:0] a;
        a = (idx < 6'd18) ? (idx - 6'd2) : (idx - 6'd4);
        return a[4:0];
    endfunction

    function automatic logic [7:0] stream_byte(input logic [1:0] sel,
                                               input logic [5:0] idx,
                                               input logic [7:0] ch);
        if (sel != SEL_REFRESH)
            return (idx == 6'd0) ? LCD_CMD_PREFIX : LCD_CLEAR;
        case (idx)
            6'd0:    return LCD_CMD_PREFIX;
            6'd1:    return LCD_LINE0;
            6'd18:   return LCD_CMD_PREFIX;
            6'd19:   return LCD_LINE1;
            default: return ch;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_frame_buf.sv
`default_nettype none
// ============================================================================
// lcd_frame_buf - 32x8 character store, synchronous write, combinational read
// Rev 1.0
// ============================================================================
module lcd_frame_buf
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_we,
    input  logic [4:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [4:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [LCD_NUM_CHARS];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < LCD_NUM_CHARS; i++)
                r_mem[i] <= LCD_SPACE;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/lcd_serial_sched.sv
`default_nettype none
// ============================================================================
// lcd_serial_sched - arbitrates init/clear/refresh byte streams onto the UART
// Rev 1.0
// ============================================================================
module lcd_serial_sched
    import lcd_pkg::*;
#(
    parameter int INIT_WAIT_CYC = 500000,
    parameter int CMD_WAIT_CYC  = 250000,
    parameter int AUTO_REFRESH  = 1
) (
    input  logic       FAB_CLK,
    input  logic       MSS_RESET_N,
    input  logic       BUF_WE,
    input  logic [4:0] BUF_ADDR,
    input  logic [7:0] BUF_WDATA,
    input  logic       CLEAR_REQ,
    input  logic       REFRESH_REQ,
    output logic [7:0] TX_DATA,
    output logic       TX_VALID,
    input  logic       TX_READY,
    output logic       BUSY,
    output logic       INIT_DONE,
    output logic       DIRTY
);

    localparam int MAX_WAIT = (INIT_WAIT_CYC > CMD_WAIT_CYC) ? INIT_WAIT_CYC : CMD_WAIT_CYC;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_WAIT_CYC - 1);

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [5:0]       r_idx;
    logic [7:0]       r_tx_data;
    logic             r_clr_pend;
    logic             r_ref_pend;
    logic             r_dirty;
    logic             r_init_done;

    logic             w_xfer;
    logic             w_last;
    logic             w_clr_any;
    logic             w_ref_any;
    logic             w_start_clr;
    logic             w_start_ref;
    logic             w_init_end;
    logic [5:0]       w_idx_nxt;
    logic [7:0]       w_rd_char;

    assign w_xfer      = (r_state == ST_SEND) && TX_READY;
    assign w_last      = (r_idx == stream_last(r_sel));
    assign w_clr_any   = r_clr_pend || CLEAR_REQ;
    assign w_ref_any   = r_ref_pend || REFRESH_REQ || ((AUTO_REFRESH != 0) && r_dirty);
    assign w_start_clr = (r_state == ST_IDLE) && w_clr_any;
    assign w_start_ref = (r_state == ST_IDLE) && !w_clr_any && w_ref_any;
    assign w_init_end  = (r_state == ST_DELAY) && (r_cnt == CMD_LAST) && (r_sel == SEL_INIT);
    assign w_idx_nxt   = r_idx + 6'd1;

    lcd_frame_buf u_frame_buf (
        .clk     (FAB_CLK),
        .rst_n   (MSS_RESET_N),
        .i_we    (BUF_WE),
        .i_waddr (BUF_ADDR),
        .i_wdata (BUF_WDATA),
        .i_raddr (refresh_addr(w_idx_nxt)),
        .o_rdata (w_rd_char)
    );

    always_ff @(posedge FAB_CLK) begin
        if (!MSS_RESET_N)
            r_state <= ST_INIT_WAIT;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_INIT_WAIT: if (r_cnt == INIT_LAST) w_next_state = ST_SEND;
            ST_IDLE:      if (w_start_clr || w_start_ref) w_next_state = ST_SEND;
            ST_SEND:      if (w_xfer && w_last)
                              w_next_state = (r_sel == SEL_REFRESH) ? ST_IDLE : ST_DELAY;
            ST_DELAY:     if (r_cnt == CMD_LAST) w_next_state = ST_IDLE;
            default:      w_next_state = ST_INIT_WAIT;
        endcase
    end

    always_comb begin
        TX_VALID = 1'b0;
        BUSY     = 1'b1;
        case (r_state)
            ST_IDLE: BUSY     = 1'b0;
            ST_SEND: TX_VALID = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (!MSS_RESET_N) begin
            r_cnt       <= '0;
            r_sel       <= SEL_INIT;
            r_idx       <= 6'd0;
            r_tx_data   <= 8'h00;
            r_clr_pend  <= 1'b0;
            r_ref_pend  <= 1'b0;
            r_dirty     <= 1'b0;
            r_init_done <= 1'b0;
        end else begin
            if (r_state != w_next_state)
                r_cnt <= '0;
            else if (r_state == ST_INIT_WAIT || r_state == ST_DELAY)
                r_cnt <= r_cnt + CNT_W'(1);

            if (w_start_clr)
                r_sel <= SEL_CLEAR;
            else if (w_start_ref)
                r_sel <= SEL_REFRESH;

            // Each byte is captured when presented so buffer writes cannot disturb a stalled byte
            if (w_next_state == ST_SEND && r_state != ST_SEND) begin
                r_idx     <= 6'd0;
                r_tx_data <= LCD_CMD_PREFIX;
            end else if (w_xfer && !w_last) begin
                r_idx     <= w_idx_nxt;
                r_tx_data <= stream_byte(r_sel, w_idx_nxt, w_rd_char);
            end

            r_clr_pend <= w_clr_any && !w_start_clr;
            r_ref_pend <= (r_ref_pend || REFRESH_REQ || w_init_end) && !w_start_ref;

            if (BUF_WE)
                r_dirty <= 1'b1;
            else if (w_start_ref)
                r_dirty <= 1'b0;

            if (w_init_end)
                r_init_done <= 1'b1;
        end
    end

    assign TX_DATA   = r_tx_data;
    assign INIT_DONE = r_init_done;
    assign DIRTY     = r_dirty;

endmodule
`default_nettype wire

// File: tb/tb_lcd_serial_sched.sv
`default_nettype none
// ============================================================================
// tb_lcd_serial_sched - directed bench with a byte-stream scoreboard model
// Rev 1.0
// ============================================================================
module tb_lcd_serial_sched;

    localparam int INIT_W = 20;
    localparam int CMD_W  = 10;

    logic       FAB_CLK = 1'b0;
    logic       MSS_RESET_N = 1'b0;
    logic       BUF_WE = 1'b0;
    logic [4:0] BUF_ADDR = 5'd0;
    logic [7:0] BUF_WDATA = 8'h00;
    logic       CLEAR_REQ = 1'b0;
    logic       REFRESH_REQ = 1'b0;
    logic       TX_READY = 1'b1;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       BUSY;
    logic       INIT_DONE;
    logic       DIRTY;

    lcd_serial_sched #(
        .INIT_WAIT_CYC (INIT_W),
        .CMD_WAIT_CYC  (CMD_W),
        .AUTO_REFRESH  (1)
    ) dut (
        .FAB_CLK     (FAB_CLK),
        .MSS_RESET_N (MSS_RESET_N),
        .BUF_WE      (BUF_WE),
        .BUF_ADDR    (BUF_ADDR),
        .BUF_WDATA   (BUF_WDATA),
        .CLEAR_REQ   (CLEAR_REQ),
        .REFRESH_REQ (REFRESH_REQ),
        .TX_DATA     (TX_DATA),
        .TX_VALID    (TX_VALID),
        .TX_READY    (TX_READY),
        .BUSY        (BUSY),
        .INIT_DONE   (INIT_DONE),
        .DIRTY       (DIRTY)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: LCD character memory plus the queue of bytes the LCD must receive
    logic [7:0] mbuf [32];
    logic [7:0] exp_q [$];
    int         gap_q [$];
    int         xfer_count   = 0;
    int         stall_cycles = 0;
    int         gap          = 0;
    logic       prev_stall   = 1'b0;
    logic [7:0] prev_data    = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic push(input logic [7:0] b, input int g);
        exp_q.push_back(b);
        gap_q.push_back(g);
    endtask

    task automatic push_cmd(input int first_gap);
        push(8'hFE, first_gap);
        push(8'h01, 0);
    endtask

    task automatic push_refresh(input int first_gap);
        push(8'hFE, first_gap);
        push(8'h80, 0);
        for (int i = 0; i < 16; i++) push(mbuf[i], 0);
        push(8'hFE, 0);
        push(8'hC0, 0);
        for (int i = 16; i < 32; i++) push(mbuf[i], 0);
    endtask

    // gap = number of TX_VALID-low cycles since the previous transfer (or reset release)
    always @(negedge FAB_CLK) begin
        if (!MSS_RESET_N) begin
            gap        = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && TX_VALID)
                check("tx_data_hold", {24'd0, TX_DATA}, {24'd0, prev_data});
            if (TX_VALID && TX_READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h, required no transfer (t=%0t)", TX_DATA, $time);
                end else begin
                    automatic logic [7:0] b = exp_q.pop_front();
                    automatic int         g = gap_q.pop_front();
                    check("tx_byte", {24'd0, TX_DATA}, {24'd0, b});
                    if (g >= 0) check("tx_gap", gap, g);
                end
                xfer_count++;
                gap = 0;
            end else if (!TX_VALID) begin
                gap++;
            end
            prev_stall = TX_VALID && !TX_READY;
            prev_data  = TX_DATA;
            if (prev_stall) stall_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge FAB_CLK);
            #1;
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || BUSY) && n < budget) begin
            tick(1);
            n++;
        end
        check(name, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic wait_xfers(input string name, input int target, input int budget);
        int n = 0;
        while (xfer_count < target && n < budget) begin
            tick(1);
            n++;
        end
        check(name, (n < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    task automatic buf_write(input logic [4:0] a, input logic [7:0] d);
        BUF_WE    = 1'b1;
        BUF_ADDR  = a;
        BUF_WDATA = d;
        mbuf[a]   = d;
        tick(1);
        BUF_WE = 1'b0;
        check("dirty_after_write", {31'd0, DIRTY}, 32'd1);
    endtask

    task automatic check_reset_state();
        check("rst_tx_valid",  {31'd0, TX_VALID}, 32'd0);
        check("rst_tx_data",   {24'd0, TX_DATA},  32'h00);
        check("rst_busy",      {31'd0, BUSY},     32'd1);
        check("rst_init_done", {31'd0, INIT_DONE}, 32'd0);
        check("rst_dirty",     {31'd0, DIRTY},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;

        // Power-on: init command, wait, forced full refresh of spaces
        tick(3);
        check_reset_state();
        MSS_RESET_N = 1'b1;
        push_cmd(INIT_W);
        push_refresh(CMD_W + 1);
        tick(5);
        check("init_not_done_yet", {31'd0, INIT_DONE}, 32'd0);
        wait_drain("drain_init", 300);
        check("init_done", {31'd0, INIT_DONE}, 32'd1);
        check("idle_after_init", {31'd0, BUSY}, 32'd0);
        check("clean_after_init", {31'd0, DIRTY}, 32'd0);
        check("init_xfers", xfer_count, 38);

        // Two writes: the first triggers auto refresh, the second lands on its start edge
        tick(3);
        buf_write(5'd0, 8'h41);
        buf_write(5'd31, 8'h42);
        push_refresh(-1);
        push_refresh(1);
        wait_drain("drain_auto", 300);
        check("clean_after_auto", {31'd0, DIRTY}, 32'd0);

        // Clear and refresh requested together: clear, delay, then one refresh
        tick(3);
        base = xfer_count;
        push_cmd(-1);
        push_refresh(CMD_W + 1);
        CLEAR_REQ   = 1'b1;
        REFRESH_REQ = 1'b1;
        tick(1);
        CLEAR_REQ   = 1'b0;
        REFRESH_REQ = 1'b0;
        wait_drain("drain_clr_ref", 300);
        tick(40);
        check("clr_ref_xfers", xfer_count - base, 38);

        // Stall on byte 3 while its character is rewritten
        base = xfer_count;
        push_refresh(-1);
        REFRESH_REQ = 1'b1;
        tick(1);
        REFRESH_REQ = 1'b0;
        wait_xfers("reach_byte3", base + 3, 100);
        base = stall_cycles;
        TX_READY  = 1'b0;
        BUF_WE    = 1'b1;
        BUF_ADDR  = 5'd1;
        BUF_WDATA = 8'h55;
        mbuf[1]   = 8'h55;
        tick(1);
        BUF_WE = 1'b0;
        check("stall_valid", {31'd0, TX_VALID}, 32'd1);
        check("stall_old_char", {24'd0, TX_DATA}, 32'h20);
        tick(4);
        check("stall_still_old", {24'd0, TX_DATA}, 32'h20);
        TX_READY = 1'b1;
        check("stall_cycles", stall_cycles - base, 5);
        base = xfer_count - 3;
        wait_xfers("finish_stalled", base + 36, 100);
        check("dirty_after_stalled", {31'd0, DIRTY}, 32'd1);
        check("idle_after_stalled", {31'd0, BUSY}, 32'd0);
        push_refresh(1);
        wait_drain("drain_second", 300);
        check("clean_after_second", {31'd0, DIRTY}, 32'd0);

        // Reset in the middle of a refresh, then coalesced requests during init
        tick(2);
        base = xfer_count;
        push_refresh(-1);
        REFRESH_REQ = 1'b1;
        tick(1);
        REFRESH_REQ = 1'b0;
        wait_xfers("reach_byte10", base + 10, 100);
        MSS_RESET_N = 1'b0;
        tick(1);
        check_reset_state();
        exp_q.delete();
        gap_q.delete();
        tick(2);
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        MSS_RESET_N = 1'b1;
        base = xfer_count;
        push_cmd(INIT_W);
        push_refresh(CMD_W + 1);
        for (int k = 0; k < 3; k++) begin
            tick(2);
            REFRESH_REQ = 1'b1;
            tick(1);
            REFRESH_REQ = 1'b0;
        end
        check("reinit_not_done", {31'd0, INIT_DONE}, 32'd0);
        wait_drain("drain_reinit", 300);
        tick(60);
        check("reinit_xfers", xfer_count - base, 38);
        check("reinit_done", {31'd0, INIT_DONE}, 32'd1);
        check("reinit_clean", {31'd0, DIRTY}, 32'd0);
        check("reinit_idle", {31'd0, BUSY}, 32'd0);
        check("queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lcd_serial_sched.md
Name: lcd_serial_sched

Overview:
- Fabric-side scheduler that owns the 2x16 character frame buffer for the serial LCD.
- Sequences every byte sent to the LCD through a shared UART byte transmitter: power-on init, clear commands and full-screen refreshes.
- Arbitrates among three request sources (init, clear, refresh) so that exactly one byte stream drives the transmitter at a time.

Parameters:
- INIT_WAIT_CYC, 500000: cycles to wait after reset before the first byte (LCD power-up).
- CMD_WAIT_CYC, 250000: cycles to wait after a clear command, before any further byte.
- AUTO_REFRESH, 1: when 1, DIRTY=1 in IDLE raises an internal refresh request.

Ports:
- FAB_CLK  in  1  fabric clock; all logic on rising edge.
- MSS_RESET_N  in  1  synchronous, active-low reset.
- BUF_WE  in  1  frame-buffer write strobe.
- BUF_ADDR  in  5  character position: 0-15 line 0, 16-31 line 1.
- BUF_WDATA  in  8  character code.
- CLEAR_REQ  in  1  single-cycle clear-display request.
- REFRESH_REQ  in  1  single-cycle full-refresh request.
- TX_DATA  out  8  byte to the UART transmitter.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  transmitter accepts a byte.
- BUSY  out  1  high whenever the block is not in IDLE.
- INIT_DONE  out  1  high once the init sequence has completed.
- DIRTY  out  1  buffer modified since the last refresh started.

Behaviour:
- Reset (MSS_RESET_N=0 at an edge):
  - TX_VALID=0, TX_DATA=0x00, BUSY=1, INIT_DONE=0, DIRTY=0.
  - Pending flags cleared; all 32 buffer entries set to 0x20.
  - State becomes INIT_WAIT.
  - Applies mid-transfer too: TX_VALID is low after that edge and the in-flight byte is abandoned.
- Handshake:
  - A byte transfers on an edge where TX_VALID=1 and TX_READY=1.
  - TX_DATA stays stable while TX_VALID=1 and TX_READY=0.
  - The next byte of the same stream is presented in the cycle after a transfer (TX_VALID stays high), giving one byte per cycle when TX_READY is held high.
  - TX_VALID drops after the last byte of a stream.
- States:
  - INIT_WAIT: count INIT_WAIT_CYC cycles, then go to SEND with the init stream.
  - IDLE: BUSY=0. Select by priority clear > refresh (pending REFRESH_REQ or AUTO_REFRESH&&DIRTY), then go to SEND next cycle.
  - SEND: present bytes per stream until the last byte transfers, then go to DELAY (clear or init stream) or IDLE (refresh stream).
  - DELAY: count CMD_WAIT_CYC cycles with TX_VALID=0. For the init stream, set INIT_DONE=1 and force a pending refresh. Then go to IDLE.
- Streams:
  - Init and clear: 0xFE, 0x01.
  - Refresh (36 bytes): 0xFE, 0x80, buf[0..15], 0xFE, 0xC0, buf[16..31].
- Request latching:
  - CLEAR_REQ and REFRESH_REQ set sticky pending flags in any state other than reset, including during init.
  - Repeated requests coalesce into one pending flag.
  - A flag is cleared in the cycle its stream is selected.
  - Simultaneous CLEAR_REQ and REFRESH_REQ: clear runs first, then refresh.
- Buffer writes:
  - Accepted in any state except reset; synchronous; buffer read is combinational.
  - Each refresh character is sampled into TX_DATA when it is presented. A write to that address while TX_VALID is held does not change TX_DATA.
  - DIRTY is set by any BUF_WE and cleared on the edge that leaves IDLE for a refresh.
  - A write and the refresh start in the same cycle leave DIRTY=1.
  - A write during a refresh leaves DIRTY=1 at completion, so AUTO_REFRESH schedules another refresh.
- Counter width is clog2(max(INIT_WAIT_CYC, CMD_WAIT_CYC)+1) bits; count to N-1, no wrap.

Decomposition:
- Shared package lcd_pkg with:
  - LCD_CMD_PREFIX=0xFE, LCD_CLEAR=0x01, LCD_LINE0=0x80, LCD_LINE1=0xC0, LCD_SPACE=0x20.
  - LCD_NUM_CHARS=32, the state encoding, and the stream-select encoding.
- One sub-module, lcd_frame_buf: 32x8 register file with synchronous write, combinational read, and synchronous reset fill to 0x20.

Test Plan (INIT_WAIT_CYC=20, CMD_WAIT_CYC=10, TX_READY=1 unless stated):
- Release reset -> TX_VALID=0 for 20 cycles; then FE,01; 10 idle cycles; INIT_DONE=1; then FE,80, sixteen 0x20, FE,C0, sixteen 0x20; BUSY=0.
- After init, write 0x41 to addr 0 and 0x42 to addr 31 -> DIRTY=1; auto refresh sends FE,80,41,20x15,FE,C0,20x15,42; DIRTY=0 at end.
- CLEAR_REQ and REFRESH_REQ in the same IDLE cycle -> FE,01, 10-cycle gap, then the 36-byte refresh; exactly one of each.
- TX_READY held low 5 cycles on byte 3 of a refresh while addr 1 is rewritten -> TX_DATA is stable with the old value for all 5 cycles; DIRTY=1 after completion; a second refresh carries the new value.
- REFRESH_REQ pulsed 3 times during init -> exactly one extra refresh is coalesced (one after init).
- Reset asserted mid-refresh at byte 10 -> TX_VALID=0 next cycle, INIT_DONE=0, buffer all 0x20, init sequence restarts.
